// File: rtl/gig_eth_tx_arb_pkg.sv
// ============================================================================
// gig_eth_tx_arb_pkg : shared state encodings and defaults for the GbE TX arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package gig_eth_tx_arb_pkg;

    localparam int C_NUM_PORTS          = 2;
    localparam int C_GAP_CYCLES_DEFAULT = 1;
    localparam int C_STAT_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_STREAM   = 2'd2,
        ST_GAP      = 2'd3
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/gig_eth_rr_pick.sv
// ============================================================================
// gig_eth_rr_pick : two-way round-robin choice, combinational
// Rev 1.0
// ============================================================================
`default_nettype none

module gig_eth_rr_pick
    import gig_eth_tx_arb_pkg::*;
(
    input  logic [C_NUM_PORTS-1:0] req,
    input  logic                   last_grant,
    output logic                   grant
);

    // A tie goes to whichever port did not finish the previous frame.
    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gig_eth_tx_arbiter.sv
// ============================================================================
// gig_eth_tx_arbiter : two-port round-robin arbiter onto a GbE MAC TX client
// Rev 1.0 ; per-port frame counters built only with GIG_ETH_TX_ARB_STATS_EN
// ============================================================================
`default_nettype none

module gig_eth_tx_arbiter
    import gig_eth_tx_arb_pkg::*;
#(
    parameter int GAP_CYCLES = C_GAP_CYCLES_DEFAULT,
    parameter int STAT_WIDTH = C_STAT_WIDTH_DEFAULT
) (
    input  logic                  tx_clk,
    input  logic                  reset,
    input  logic [7:0]            req0_data,
    input  logic                  req0_dvld,
    input  logic                  req0_underrun,
    output logic                  req0_ack,
    input  logic [7:0]            req1_data,
    input  logic                  req1_dvld,
    input  logic                  req1_underrun,
    output logic                  req1_ack,
    output logic [7:0]            mac_tx_data,
    output logic                  mac_tx_dvld,
    output logic                  mac_tx_underrun,
    input  logic                  mac_tx_ack,
    output logic [STAT_WIDTH-1:0] frames_sent0,
    output logic [STAT_WIDTH-1:0] frames_sent1
);

    localparam logic [3:0] C_GAP_LAST = 4'(GAP_CYCLES - 1);

    arb_state_e             state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [3:0]             gap_cnt_q, gap_cnt_d;
    logic [C_NUM_PORTS-1:0] w_req;
    logic                   w_pick;
    logic [7:0]             w_sel_data;
    logic                   w_sel_dvld;
    logic                   w_sel_underrun;

    assign w_req          = {req1_dvld, req0_dvld};
    assign w_sel_data     = grant_q ? req1_data     : req0_data;
    assign w_sel_dvld     = grant_q ? req1_dvld     : req0_dvld;
    assign w_sel_underrun = grant_q ? req1_underrun : req0_underrun;

    gig_eth_rr_pick u_rr_pick (
        .req        (w_req),
        .last_grant (last_grant_q),
        .grant      (w_pick)
    );

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        gap_cnt_d       = gap_cnt_q;
        mac_tx_data     = 8'h00;
        mac_tx_dvld     = 1'b0;
        mac_tx_underrun = 1'b0;
        req0_ack        = 1'b0;
        req1_ack        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|w_req) begin
                    grant_d = w_pick;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                mac_tx_data     = w_sel_data;
                mac_tx_dvld     = w_sel_dvld;
                mac_tx_underrun = w_sel_underrun;
                req0_ack        = mac_tx_ack & ~grant_q;
                req1_ack        = mac_tx_ack &  grant_q;
                // An ack in the same cycle as a dropped request still starts the frame.
                if (mac_tx_ack) begin
                    state_d = ST_STREAM;
                end else if (!w_sel_dvld) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                mac_tx_data     = w_sel_data;
                mac_tx_dvld     = w_sel_dvld;
                mac_tx_underrun = w_sel_underrun;
                if (!w_sel_dvld) begin
                    state_d      = ST_GAP;
                    last_grant_d = grant_q;
                    gap_cnt_d    = 4'd0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == C_GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs stay quiet for the whole reset cycle, not just after it.
        if (reset) begin
            mac_tx_data     = 8'h00;
            mac_tx_dvld     = 1'b0;
            mac_tx_underrun = 1'b0;
            req0_ack        = 1'b0;
            req1_ack        = 1'b0;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            gap_cnt_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

`ifdef GIG_ETH_TX_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] cnt0_q;
    logic [STAT_WIDTH-1:0] cnt1_q;
    logic                  w_frame_done;

    assign w_frame_done = (state_q == ST_STREAM) && !w_sel_dvld;

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (w_frame_done) begin
            if (grant_q) begin
                cnt1_q <= cnt1_q + STAT_WIDTH'(1);
            end else begin
                cnt0_q <= cnt0_q + STAT_WIDTH'(1);
            end
        end
    end

    assign frames_sent0 = cnt0_q;
    assign frames_sent1 = cnt1_q;
`else
    assign frames_sent0 = '0;
    assign frames_sent1 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gig_eth_tx_arbiter.sv
// ============================================================================
// tb_gig_eth_tx_arbiter : frame-level sources, MAC responder and timing model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gig_eth_tx_arbiter;

    localparam int GAP = 1;
`ifdef GIG_ETH_TX_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        tx_clk = 1'b0;
    logic        reset;
    logic [7:0]  req0_data, req1_data;
    logic        req0_dvld, req1_dvld, req0_underrun, req1_underrun;
    logic        req0_ack, req1_ack;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_dvld, mac_tx_underrun, mac_tx_ack;
    logic [15:0] frames_sent0, frames_sent1;

    gig_eth_tx_arbiter #(.GAP_CYCLES(GAP), .STAT_WIDTH(16)) dut (
        .tx_clk(tx_clk), .reset(reset),
        .req0_data(req0_data), .req0_dvld(req0_dvld), .req0_underrun(req0_underrun), .req0_ack(req0_ack),
        .req1_data(req1_data), .req1_dvld(req1_dvld), .req1_underrun(req1_underrun), .req1_ack(req1_ack),
        .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld), .mac_tx_underrun(mac_tx_underrun),
        .mac_tx_ack(mac_tx_ack), .frames_sent0(frames_sent0), .frames_sent1(frames_sent1)
    );

    always #5 tx_clk = ~tx_clk;

    int checks, errors, cyc, rst_cycles, rst_byte;
    // frame sources
    int s_active[2], s_len[2], s_idx[2], s_acked[2], s_wait[2], s_abort[2], s_urun[2];
    logic [7:0] s_bytes[2][256];
    // MAC responder
    int ack_delay, mac_wait, mac_got, spur_en, noise_en;
    logic ack_next;
    // expectation: frame ownership in time, not state encodings
    int m_in_frame, m_acked, m_win, m_last, m_free_at;
    int m_cnt[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        reset         = (rst_cycles > 0);
        req0_dvld     = (s_active[0] != 0);
        req0_data     = (s_active[0] != 0) ? s_bytes[0][s_idx[0]] : 8'h00;
        req0_underrun = (s_active[0] != 0) && (s_idx[0] == s_urun[0]);
        req1_dvld     = (s_active[1] != 0);
        req1_data     = (s_active[1] != 0) ? s_bytes[1][s_idx[1]] : 8'h00;
        req1_underrun = (s_active[1] != 0) && (s_idx[1] == s_urun[1]);
        mac_tx_ack    = ack_next;
    endtask

    task automatic start_src(input int p, input int len, input int abort_after, input int urun_at);
        for (int i = 0; i < len; i++) begin
            s_bytes[p][i] = (p == 1) ? (8'h80 | 8'($urandom_range(0, 127))) : 8'($urandom_range(0, 127));
        end
        s_len[p] = len; s_idx[p] = 0; s_acked[p] = 0; s_wait[p] = 0;
        s_abort[p] = abort_after; s_urun[p] = urun_at; s_active[p] = 1;
    endtask

    function automatic int rr(input logic r0, input logic r1, input int last);
        if (r0 && r1) return 1 - last;
        return r1 ? 1 : 0;
    endfunction

    task automatic step();
        logic [11:0] e_o;
        logic        sel_dvld;
        logic        got;
        @(negedge tx_clk);
        e_o = 12'h000;
        if (!reset && m_in_frame != 0) begin
            if (m_win == 1)
                e_o = {req1_dvld, req1_underrun, req1_data, mac_tx_ack && (m_acked == 0), 1'b0};
            else
                e_o = {req0_dvld, req0_underrun, req0_data, 1'b0, mac_tx_ack && (m_acked == 0)};
        end
        chk("outputs{dvld,urun,data,ack1,ack0}",
            {20'h0, mac_tx_dvld, mac_tx_underrun, mac_tx_data, req1_ack, req0_ack}, {20'h0, e_o});
        chk("frames_sent{1,0}", {frames_sent1, frames_sent0},
            STATS ? {16'(m_cnt[1] % 65536), 16'(m_cnt[0] % 65536)} : 32'h0);

        // expectation update
        sel_dvld = (m_win == 1) ? req1_dvld : req0_dvld;
        if (reset) begin
            m_in_frame = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0; m_free_at = cyc + 1;
        end else if (m_in_frame == 0) begin
            if (cyc >= m_free_at && (req0_dvld || req1_dvld)) begin
                m_win = rr(req0_dvld, req1_dvld, m_last); m_in_frame = 1; m_acked = 0;
            end
        end else if (m_acked == 0) begin
            if (mac_tx_ack) m_acked = 1;
            else if (!sel_dvld) begin m_in_frame = 0; m_free_at = cyc + 1; end
        end else if (!sel_dvld) begin
            m_in_frame = 0; m_last = m_win; m_cnt[m_win]++; m_free_at = cyc + 1 + GAP;
        end

        // sources react to their own ack
        for (int p = 0; p < 2; p++) begin
            if (s_active[p] != 0) begin
                got = (p == 1) ? req1_ack : req0_ack;
                if (s_acked[p] != 0 || got) begin
                    s_acked[p] = 1; s_idx[p]++;
                    if (s_idx[p] >= s_len[p]) s_active[p] = 0;
                end else begin
                    s_wait[p]++;
                    if (s_abort[p] > 0 && s_wait[p] >= s_abort[p]) s_active[p] = 0;
                end
            end
        end
        if (reset) begin s_active[0] = 0; s_active[1] = 0; end

        // MAC responder
        ack_next = 1'b0;
        if (mac_tx_dvld) begin
            if (mac_got == 0) begin
                mac_wait++;
                if (mac_wait == ack_delay) begin ack_next = 1'b1; mac_got = 1; end
            end else if (spur_en != 0 && $urandom_range(0, 4) == 0) begin
                ack_next = 1'b1;
            end
        end else begin
            mac_wait = 0; mac_got = 0;
        end
        if (noise_en != 0) ack_next = 1'($urandom_range(0, 1));

        if (rst_cycles > 0) rst_cycles--;
        if (rst_byte >= 0 && s_active[0] != 0 && s_acked[0] != 0 && s_idx[0] == rst_byte) begin
            rst_cycles = 1; rst_byte = -1;
        end
        cyc++;
        @(posedge tx_clk);
        #1;
        drive();
    endtask

    task automatic run_round();
        int budget;
        budget = 0;
        while ((s_active[0] != 0 || s_active[1] != 0 || m_in_frame != 0) && budget < 3000) begin
            step();
            budget++;
        end
        checks++;
        assert (budget < 3000) else begin
            errors++;
            $error("FAIL round_timeout: observed %0d cycles expected < 3000", budget);
        end
        repeat (GAP + 3) step();
    endtask

    initial begin
        int mask, l0, l1;
        checks = 0; errors = 0; cyc = 0; rst_cycles = 3; rst_byte = -1;
        s_active = '{0, 0}; s_idx = '{0, 0}; s_urun = '{-1, -1};
        ack_delay = 1; mac_wait = 0; mac_got = 0; spur_en = 0; noise_en = 0; ack_next = 1'b0;
        m_in_frame = 0; m_acked = 0; m_win = 0; m_last = 1; m_free_at = 0; m_cnt = '{0, 0};
        drive();
        repeat (5) step();
        chk("reset_idle_dvld", {31'h0, mac_tx_dvld}, 32'h0);

        // single port 0 frame, 60 bytes, ack 10 cycles after request
        ack_delay = 9;
        start_src(0, 60, 0, -1); drive();
        run_round();
        chk("single_cnt0", {16'h0, frames_sent0}, STATS ? 32'd1 : 32'd0);
        chk("single_cnt1", {16'h0, frames_sent1}, 32'h0);

        // two ties in a row: 0 then 1, then 0 wins again
        ack_delay = 3;
        start_src(0, 20, 0, -1); start_src(1, 15, 0, -1); drive(); run_round();
        start_src(0, 7, 0, -1);  start_src(1, 9, 0, -1);  drive(); run_round();

        // port 0 frame, then port 1 aborts before any ack, then port 1 wins the tie
        start_src(0, 4, 0, -1); drive(); run_round();
        ack_delay = 50;
        start_src(1, 12, 3, -1); drive(); run_round();
        ack_delay = 2;
        start_src(0, 5, 0, -1); start_src(1, 6, 0, -1); drive(); run_round();

        // underrun pulse mid-frame passes through
        start_src(0, 64, 0, 20); drive(); run_round();

        // reset while streaming byte 30, then a normal grant
        rst_byte = 30;
        start_src(0, 64, 0, -1); drive(); run_round();
        chk("post_reset_counters", {frames_sent1, frames_sent0}, 32'h0);
        start_src(1, 8, 0, -1); drive(); run_round();

        // randomized rounds with stray MAC acks
        spur_en = 1;
        for (int r = 0; r < 40; r++) begin
            mask = $urandom_range(1, 3);
            ack_delay = $urandom_range(1, 6);
            l0 = $urandom_range(1, 24);
            l1 = $urandom_range(1, 24);
            if ((mask & 1) != 0) start_src(0, l0, 0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, l0)) : -1);
            if ((mask & 2) != 0) start_src(1, l1, 0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, l1)) : -1);
            drive();
            run_round();
            noise_en = 1; repeat (3) step();
            noise_en = 0; step();
        end
        spur_en = 0;

`ifdef GIG_ETH_TX_ARB_STATS_EN
        force dut.cnt0_q = 16'hFFFF;
        m_cnt[0] = 65535;
        step(); step();
        release dut.cnt0_q;
        ack_delay = 2;
        start_src(0, 10, 0, -1); drive(); run_round();
        chk("wrap_cnt0", {16'h0, frames_sent0}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
